// File: rtl/id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_stage
//
// Purpose:
//   ID/EX pipeline register with load-use hazard detection. A load in ID/EX
//   whose destination is read by the instruction in ID causes a one-cycle
//   bubble. PC and IF/ID are frozen for that cycle. An EX-stage redirect
//   (flush) discards the decode instruction and takes priority over a stall.
//   A saturating counter records the number of stall cycles.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   if_id_*             decode-slot instruction fields (valid, register
//                       indices, source-use flags, operands, imm, pc, ctrl)
//   flush               EX redirect: replace the decode instruction with a bubble
//   pc_write            PC enable (combinational, low only while stalling)
//   if_id_write         IF/ID enable (combinational, same value as pc_write)
//   id_ex_*             registered copy of the decode fields for EX/forwarding
//   stall_count         saturating count of stall cycles
//
// ctrl bit order: {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc,
//                  ALUOp[1:0], Jump}
// ---------------------------------------------------------------------------
module id_ex_hazard_stage #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_id_valid,
  input  logic [4:0]        if_id_Rs1,
  input  logic [4:0]        if_id_Rs2,
  input  logic [4:0]        if_id_rd,
  input  logic              if_id_uses_rs1,
  input  logic              if_id_uses_rs2,
  input  logic [DATA_W-1:0] if_id_rs1_data,
  input  logic [DATA_W-1:0] if_id_rs2_data,
  input  logic [DATA_W-1:0] if_id_imm,
  input  logic [DATA_W-1:0] if_id_pc,
  input  logic [8:0]        if_id_ctrl,
  input  logic              flush,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_valid,
  output logic [4:0]        id_ex_Rs1,
  output logic [4:0]        id_ex_Rs2,
  output logic [4:0]        id_ex_rd,
  output logic [DATA_W-1:0] id_ex_rs1_data,
  output logic [DATA_W-1:0] id_ex_rs2_data,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [DATA_W-1:0] id_ex_pc,
  output logic [8:0]        id_ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int MEMREAD_BIT = 7;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              valid_q, valid_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [8:0]        ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic hazard;
  logic stall;
  logic rs1_match;
  logic rs2_match;

  // Load-use detection works from the registered load in ID/EX against the
  // live decode instruction. rd = 0 loads never stall because x0 is never
  // really written.
  always_comb begin
    rs1_match = if_id_uses_rs1 & (if_id_Rs1 == rd_q);
    rs2_match = if_id_uses_rs2 & (if_id_Rs2 == rd_q);
    hazard    = valid_q & ctrl_q[MEMREAD_BIT] & (rd_q != 5'd0) &
                if_id_valid & (rs1_match | rs2_match);
    stall     = hazard & ~flush;
  end

  // Reset forces the enables high so fetch resumes immediately afterwards.
  assign pc_write    = ~(stall & ~reset);
  assign if_id_write = ~(stall & ~reset);

  always_comb begin
    // Bubble by default: zero control and indices so nothing forwards or
    // writes back, and zero data for a clean, deterministic slot.
    valid_d    = 1'b0;
    rs1_d      = 5'd0;
    rs2_d      = 5'd0;
    rd_d       = 5'd0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    pc_d       = '0;
    ctrl_d     = 9'd0;
    cnt_d      = cnt_q;

    if (flush) begin
      // Redirect wins: bubble, and the discarded hazard is not a stall.
      cnt_d = cnt_q;
    end else if (stall) begin
      cnt_d = sat_inc(cnt_q);
    end else begin
      valid_d    = if_id_valid;
      rs1_data_d = if_id_rs1_data;
      rs2_data_d = if_id_rs2_data;
      imm_d      = if_id_imm;
      pc_d       = if_id_pc;
      // An empty decode slot must not carry register indices or control
      // that the forwarding unit or writeback could act on.
      if (if_id_valid) begin
        rs1_d  = if_id_Rs1;
        rs2_d  = if_id_Rs2;
        rd_d   = if_id_rd;
        ctrl_d = if_id_ctrl;
      end
    end
  end

  // ID -> EX register boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      ctrl_q     <= 9'd0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign id_ex_valid    = valid_q;
  assign id_ex_Rs1      = rs1_q;
  assign id_ex_Rs2      = rs2_q;
  assign id_ex_rd       = rd_q;
  assign id_ex_rs1_data = rs1_data_q;
  assign id_ex_rs2_data = rs2_data_q;
  assign id_ex_imm      = imm_q;
  assign id_ex_pc       = pc_q;
  assign id_ex_ctrl     = ctrl_q;
  assign stall_count    = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_hazard_stage
//
// Directed bench for id_ex_hazard_stage. Two instances share all inputs:
// dut uses default parameters, dut2 uses CNT_W = 2 to exercise saturation.
// Inputs change 1 time unit after the rising edge; registered outputs are
// checked 1 unit after the edge, combinational outputs 2 units after it.
// ---------------------------------------------------------------------------
module tb_id_ex_hazard_stage;

  localparam int DW = 64;
  localparam logic [8:0] CTRL_ADD = 9'b1_0000_0000;
  localparam logic [8:0] CTRL_LD  = 9'b1_1010_1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_id_valid;
  logic [4:0]    if_id_Rs1, if_id_Rs2, if_id_rd;
  logic          if_id_uses_rs1, if_id_uses_rs2;
  logic [DW-1:0] if_id_rs1_data, if_id_rs2_data, if_id_imm, if_id_pc;
  logic [8:0]    if_id_ctrl;
  logic          flush;

  logic          pc_write, if_id_write, id_ex_valid;
  logic [4:0]    id_ex_Rs1, id_ex_Rs2, id_ex_rd;
  logic [DW-1:0] id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_pc;
  logic [8:0]    id_ex_ctrl;
  logic [15:0]   stall_count;

  logic          pc_write2, if_id_write2, id_ex_valid2;
  logic [4:0]    id_ex_Rs1_2, id_ex_Rs2_2, id_ex_rd2;
  logic [DW-1:0] id_ex_rs1_data2, id_ex_rs2_data2, id_ex_imm2, id_ex_pc2;
  logic [8:0]    id_ex_ctrl2;
  logic [1:0]    stall_count2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .if_id_valid(if_id_valid),
    .if_id_Rs1(if_id_Rs1), .if_id_Rs2(if_id_Rs2), .if_id_rd(if_id_rd),
    .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
    .if_id_rs1_data(if_id_rs1_data), .if_id_rs2_data(if_id_rs2_data),
    .if_id_imm(if_id_imm), .if_id_pc(if_id_pc), .if_id_ctrl(if_id_ctrl),
    .flush(flush), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_valid(id_ex_valid), .id_ex_Rs1(id_ex_Rs1), .id_ex_Rs2(id_ex_Rs2),
    .id_ex_rd(id_ex_rd), .id_ex_rs1_data(id_ex_rs1_data),
    .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
    .id_ex_pc(id_ex_pc), .id_ex_ctrl(id_ex_ctrl), .stall_count(stall_count)
  );

  id_ex_hazard_stage #(.DATA_W(DW), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .if_id_valid(if_id_valid),
    .if_id_Rs1(if_id_Rs1), .if_id_Rs2(if_id_Rs2), .if_id_rd(if_id_rd),
    .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
    .if_id_rs1_data(if_id_rs1_data), .if_id_rs2_data(if_id_rs2_data),
    .if_id_imm(if_id_imm), .if_id_pc(if_id_pc), .if_id_ctrl(if_id_ctrl),
    .flush(flush), .pc_write(pc_write2), .if_id_write(if_id_write2),
    .id_ex_valid(id_ex_valid2), .id_ex_Rs1(id_ex_Rs1_2), .id_ex_Rs2(id_ex_Rs2_2),
    .id_ex_rd(id_ex_rd2), .id_ex_rs1_data(id_ex_rs1_data2),
    .id_ex_rs2_data(id_ex_rs2_data2), .id_ex_imm(id_ex_imm2),
    .id_ex_pc(id_ex_pc2), .id_ex_ctrl(id_ex_ctrl2), .stall_count(stall_count2)
  );

  // Present one instruction in the decode slot; operands derive from pc.
  task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic u1, input logic u2,
                     input logic [8:0] ctrl, input logic [DW-1:0] pc);
    if_id_valid    = v;
    if_id_Rs1      = r1;
    if_id_Rs2      = r2;
    if_id_rd       = rd;
    if_id_uses_rs1 = u1;
    if_id_uses_rs2 = u2;
    if_id_ctrl     = ctrl;
    if_id_pc       = pc;
    if_id_rs1_data = pc + 64'd1;
    if_id_rs2_data = pc + 64'd2;
    if_id_imm      = pc + 64'd3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    drv(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, CTRL_LD, 64'h40);
    tick();
    #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL reset_pc_write got %0b exp 1", pc_write); end
    #1;
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 9'd0, 64'h0);
    tick();
    reset = 1'b0;
    exp_cnt = 16'd0;
    n_cmp++; if (id_ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b exp 0", id_ex_valid); end
    n_cmp++; if ({id_ex_Rs1, id_ex_Rs2, id_ex_rd} !== 15'd0) begin n_bad++; $display("FAIL reset_regs got %h exp 0", {id_ex_Rs1, id_ex_Rs2, id_ex_rd}); end
    n_cmp++; if (id_ex_ctrl !== 9'd0) begin n_bad++; $display("FAIL reset_ctrl got %h exp 0", id_ex_ctrl); end
    n_cmp++; if ({id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_pc} !== 256'd0) begin n_bad++; $display("FAIL reset_data got nonzero exp 0"); end
    n_cmp++; if (stall_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", stall_count); end
    #1;
    n_cmp++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin n_bad++; $display("FAIL reset_enables got %0b%0b exp 11", pc_write, if_id_write); end
  endtask

  task automatic test_add();
    drv(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, CTRL_ADD, 64'h100);
    #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL add_pc_write got %0b exp 1", pc_write); end
    tick();
    n_cmp++; if (id_ex_rd !== 5'd3 || id_ex_Rs1 !== 5'd1 || id_ex_Rs2 !== 5'd2) begin n_bad++; $display("FAIL add_regs got %0d/%0d/%0d exp 3/1/2", id_ex_rd, id_ex_Rs1, id_ex_Rs2); end
    n_cmp++; if (id_ex_valid !== 1'b1 || id_ex_ctrl !== CTRL_ADD) begin n_bad++; $display("FAIL add_ctrl got %0b/%h exp 1/%h", id_ex_valid, id_ex_ctrl, CTRL_ADD); end
    n_cmp++; if (id_ex_pc !== 64'h100 || id_ex_rs1_data !== 64'h101 || id_ex_rs2_data !== 64'h102 || id_ex_imm !== 64'h103) begin n_bad++; $display("FAIL add_data got pc %h exp 100", id_ex_pc); end
    n_cmp++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL add_pc_write2 got %0b exp 1", pc_write); end
  endtask

  task automatic test_load_use();
    drv(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LD, 64'h200);
    tick();
    drv(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CTRL_ADD, 64'h204);
    #1;
    n_cmp++; if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin n_bad++; $display("FAIL lu_stall_en got %0b%0b exp 00", pc_write, if_id_write); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if (id_ex_valid !== 1'b0 || id_ex_ctrl !== 9'd0 || id_ex_rd !== 5'd0) begin n_bad++; $display("FAIL lu_bubble got v%0b c%h rd%0d exp 0/0/0", id_ex_valid, id_ex_ctrl, id_ex_rd); end
    n_cmp++; if (id_ex_pc !== 64'd0) begin n_bad++; $display("FAIL lu_bubble_pc got %h exp 0", id_ex_pc); end
    n_cmp++; if (stall_count !== exp_cnt) begin n_bad++; $display("FAIL lu_count got %0d exp %0d", stall_count, exp_cnt); end
    #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL lu_release got %0b exp 1", pc_write); end
    tick();
    n_cmp++; if (id_ex_rd !== 5'd6 || id_ex_Rs1 !== 5'd5 || id_ex_valid !== 1'b1 || id_ex_pc !== 64'h204) begin n_bad++; $display("FAIL lu_capture got rd%0d rs1%0d exp 6/5", id_ex_rd, id_ex_Rs1); end
    n_cmp++; if (stall_count !== exp_cnt) begin n_bad++; $display("FAIL lu_count2 got %0d exp %0d", stall_count, exp_cnt); end
  endtask

  task automatic test_no_stall();
    drv(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, CTRL_LD, 64'h300);
    tick();
    drv(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, CTRL_ADD, 64'h304);
    #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL x0_pc_write got %0b exp 1", pc_write); end
    tick();
    n_cmp++; if (id_ex_rd !== 5'd8 || stall_count !== exp_cnt) begin n_bad++; $display("FAIL x0_capture got rd%0d cnt%0d exp 8/%0d", id_ex_rd, stall_count, exp_cnt); end
    drv(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LD, 64'h308);
    tick();
    drv(1'b1, 5'd9, 5'd5, 5'd10, 1'b1, 1'b0, CTRL_ADD, 64'h30c);
    #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL unused_rs2_pc_write got %0b exp 1", pc_write); end
    tick();
    n_cmp++; if (id_ex_rd !== 5'd10 || stall_count !== exp_cnt) begin n_bad++; $display("FAIL unused_rs2_capture got rd%0d cnt%0d exp 10/%0d", id_ex_rd, stall_count, exp_cnt); end
    // Empty decode slot: indices and control must be scrubbed.
    drv(1'b0, 5'd11, 5'd12, 5'd13, 1'b1, 1'b1, CTRL_LD, 64'h310);
    tick();
    n_cmp++; if (id_ex_valid !== 1'b0 || id_ex_ctrl !== 9'd0 || {id_ex_Rs1, id_ex_Rs2, id_ex_rd} !== 15'd0) begin n_bad++; $display("FAIL invalid_capture got v%0b c%h rd%0d exp 0/0/0", id_ex_valid, id_ex_ctrl, id_ex_rd); end
  endtask

  task automatic test_flush();
    drv(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LD, 64'h400);
    tick();
    drv(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CTRL_ADD, 64'h404);
    flush = 1'b1;
    #1;
    n_cmp++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin n_bad++; $display("FAIL flush_enables got %0b%0b exp 11", pc_write, if_id_write); end
    tick();
    flush = 1'b0;
    n_cmp++; if (id_ex_valid !== 1'b0 || id_ex_ctrl !== 9'd0 || id_ex_rd !== 5'd0) begin n_bad++; $display("FAIL flush_bubble got v%0b c%h rd%0d exp 0/0/0", id_ex_valid, id_ex_ctrl, id_ex_rd); end
    n_cmp++; if (stall_count !== exp_cnt) begin n_bad++; $display("FAIL flush_count got %0d exp %0d", stall_count, exp_cnt); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp2;
    reset = 1'b1;
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 9'd0, 64'h0);
    tick();
    reset = 1'b0;
    exp_cnt = 16'd0;
    exp2 = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LD, 64'h500);
      tick();
      drv(1'b1, 5'd2, 5'd5, 5'd6, 1'b1, 1'b1, CTRL_ADD, 64'h504);
      tick();
      exp_cnt = exp_cnt + 16'd1;
      if (exp2 != 2'd3) exp2 = exp2 + 2'd1;
      n_cmp++; if (stall_count2 !== exp2) begin n_bad++; $display("FAIL sat_count%0d got %0d exp %0d", i, stall_count2, exp2); end
      n_cmp++; if (stall_count !== exp_cnt) begin n_bad++; $display("FAIL wide_count%0d got %0d exp %0d", i, stall_count, exp_cnt); end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    drv(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LD, 64'h600);
    tick();
    drv(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CTRL_ADD, 64'h604);
    #1;
    n_cmp++; if (pc_write !== 1'b0) begin n_bad++; $display("FAIL rms_stall got %0b exp 0", pc_write); end
    reset = 1'b1;
    #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL rms_reset_en got %0b exp 1", pc_write); end
    tick();
    reset = 1'b0;
    exp_cnt = 16'd0;
    n_cmp++; if (id_ex_valid !== 1'b0 || id_ex_rd !== 5'd0 || stall_count !== exp_cnt) begin n_bad++; $display("FAIL rms_bubble got v%0b rd%0d cnt%0d exp 0/0/0", id_ex_valid, id_ex_rd, stall_count); end
    #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL rms_after got %0b exp 1", pc_write); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_no_stall();
    test_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
